// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if: handshake bundle between the PLL lock sequencer and its environment
// Ports (slave = sequencer side):
//   pll_locked, restart              : into the sequencer
//   pll_rst, sys_rst_n, ready, fail  : sequencer status/reset outputs
//   retry_cnt, loss_cnt              : sequencer counters
interface pll_lock_sequencer_if #(
  parameter int MAX_RETRIES = 3
);
  logic pll_locked;
  logic restart;
  logic pll_rst;
  logic sys_rst_n;
  logic ready;
  logic fail;
  logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt;
  logic [7:0] loss_cnt;
  modport master (
    output pll_locked, restart,
    input  pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_cnt
  );
  modport slave (
    input  pll_locked, restart,
    output pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset pulse, lock qualification, CPU reset release and bounded retry
// Ports:
//   refclk : free-running reference clock, all logic on its rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : pll_lock_sequencer_if.slave (pll_locked, restart in; pll_rst, sys_rst_n,
//            ready, fail, retry_cnt, loss_cnt out)
// Optional feature macro PLL_SEQ_LOSS_CNT_EN: saturating lock-loss counter on loss_cnt,
// otherwise loss_cnt is tied to zero.
module pll_lock_sequencer #(
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES    = 3
) (
  input logic refclk,
  input logic rst_n,
  pll_lock_sequencer_if.slave bus
);
  localparam int RW = $clog2(MAX_RETRIES+1);
  localparam int CW = $clog2(RST_CYCLES+1);
  localparam int SW = $clog2(STABLE_CYCLES+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  typedef enum logic [2:0] {RESET, WAIT_LOCK, STABLE, RUN, FAIL} state_t;
  state_t state, state_n;
  logic sync_1, lock_s;
  logic [CW-1:0] rst_cnt, rst_cnt_n;
  logic [SW-1:0] stab_cnt, stab_cnt_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic [RW-1:0] retry_q, retry_n;
  logic tmo_hit;
  assign tmo_hit = tmo_cnt == TW'(TIMEOUT_CYCLES-1);
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      sync_1 <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync_1 <= bus.pll_locked;
      lock_s <= sync_1;
    end
  always_comb begin
    state_n    = state;
    rst_cnt_n  = rst_cnt;
    stab_cnt_n = stab_cnt;
    tmo_cnt_n  = tmo_cnt;
    retry_n    = retry_q;
    if (bus.restart) begin
      state_n    = RESET;
      stab_cnt_n = '0;
      tmo_cnt_n  = '0;
      retry_n    = '0;
    end else begin
      case (state)
        RESET:
          if (rst_cnt == CW'(RST_CYCLES-1)) begin
            state_n   = WAIT_LOCK;
            tmo_cnt_n = '0;
          end else rst_cnt_n = rst_cnt + CW'(1);
        WAIT_LOCK, STABLE:
          // the stable count is compared after it is registered, so release takes
          // one extra cycle after the last qualifying sample; reaching RUN on the
          // final timeout cycle still counts as in time
          if (state == STABLE && lock_s && stab_cnt == SW'(STABLE_CYCLES)) state_n = RUN;
          else if (tmo_hit) begin
            retry_n = retry_q + RW'(1);
            state_n = (retry_q == RW'(MAX_RETRIES-1)) ? FAIL : RESET;
          end else begin
            tmo_cnt_n  = tmo_cnt + TW'(1);
            state_n    = lock_s ? STABLE : WAIT_LOCK;
            stab_cnt_n = (state == STABLE && lock_s) ? stab_cnt + SW'(1) : '0;
          end
        RUN:
          if (!lock_s) state_n = RESET;
        default: ;
      endcase
    end
    // the pulse count restarts on every entry into RESET
    if (state_n != RESET || bus.restart) rst_cnt_n = '0;
  end
  // outputs are flopped from the next-state decode so each is a single glitch-free flop
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      state         <= RESET;
      rst_cnt       <= '0;
      stab_cnt      <= '0;
      tmo_cnt       <= '0;
      retry_q       <= '0;
      bus.pll_rst   <= 1'b1;
      bus.sys_rst_n <= 1'b0;
      bus.ready     <= 1'b0;
      bus.fail      <= 1'b0;
    end else begin
      state         <= state_n;
      rst_cnt       <= rst_cnt_n;
      stab_cnt      <= stab_cnt_n;
      tmo_cnt       <= tmo_cnt_n;
      retry_q       <= retry_n;
      bus.pll_rst   <= state_n == RESET;
      bus.sys_rst_n <= state_n == RUN;
      bus.ready     <= state_n == RUN;
      bus.fail      <= state_n == FAIL;
    end
  assign bus.retry_cnt = retry_q;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_q;
  logic lost;
  // restart takes priority, so a coincident lock loss is not counted
  assign lost = state == RUN && !lock_s && !bus.restart;
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) loss_q <= 8'h00;
    else if (lost && loss_q != 8'hff) loss_q <= loss_q + 8'h01;
  assign bus.loss_cnt = loss_q;
`else
  assign bus.loss_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed and randomized checks of pll_lock_sequencer against a behavioural model
module tb_pll_lock_sequencer;
  localparam int RST = 4, STB = 8, TMO = 32, MR = 2;
  localparam int PULSE = 0, ARM = 1, RUNNING = 2, DEAD = 3;
  localparam int S_PLLRST = 0, S_SYS = 1, S_READY = 2, S_FAIL = 3;
`ifdef PLL_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif
  logic refclk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0, checks = 0;
  pll_lock_sequencer_if #(.MAX_RETRIES(MR)) bus();
  pll_lock_sequencer #(
    .RST_CYCLES(RST), .STABLE_CYCLES(STB), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MR)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #10 refclk = ~refclk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: lock_s is the locked value sampled two edges earlier; the arming window
  // (pll reset released, not yet running) succeeds once STB+2 consecutive high
  // lock_s samples are seen (entry, STB counted samples, compare), else times out
  // after TMO edges.
  typedef struct {
    int phase, left, age, streak, retry, loss;
    bit h_old, h_new;
  } mdl_t;
  mdl_t m;
  function automatic mdl_t init_m();
    mdl_t r;
    r.phase = PULSE; r.left = RST; r.age = 0; r.streak = 0; r.retry = 0; r.loss = 0;
    r.h_old = 1'b0; r.h_new = 1'b0;
    return r;
  endfunction
  function automatic mdl_t next_m(input mdl_t c, input bit locked, input bit rs);
    mdl_t n;
    bit l;
    n = c;
    l = c.h_old;
    n.h_old = c.h_new;
    n.h_new = locked;
    if (rs) begin
      n.phase = PULSE; n.left = RST; n.retry = 0;
    end else if (c.phase == PULSE) begin
      n.left = c.left - 1;
      if (n.left == 0) begin n.phase = ARM; n.age = 0; n.streak = 0; end
    end else if (c.phase == ARM) begin
      n.streak = l ? c.streak + 1 : 0;
      n.age = c.age + 1;
      if (n.streak == STB + 2) n.phase = RUNNING;
      else if (n.age == TMO) begin
        n.retry = c.retry + 1;
        n.phase = (n.retry == MR) ? DEAD : PULSE;
        n.left = RST;
      end
    end else if (c.phase == RUNNING && !l) begin
      n.phase = PULSE; n.left = RST;
      if (LOSS_EN && c.loss < 255) n.loss = c.loss + 1;
    end
    return n;
  endfunction
  always @(posedge refclk or negedge rst_n)
    m <= !rst_n ? init_m() : next_m(m, bus.pll_locked, bus.restart);
  always @(negedge refclk) begin
    chk("pll_rst", bus.pll_rst, m.phase == PULSE);
    chk("sys_rst_n", bus.sys_rst_n, m.phase == RUNNING);
    chk("ready", bus.ready, m.phase == RUNNING);
    chk("fail", bus.fail, m.phase == DEAD);
    chk("retry_cnt", bus.retry_cnt, m.retry);
    chk("loss_cnt", bus.loss_cnt, m.loss);
  end
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask
  function automatic bit sig(input int s);
    return s == S_PLLRST ? bus.pll_rst : s == S_SYS ? bus.sys_rst_n : s == S_READY ? bus.ready : bus.fail;
  endfunction
  task automatic wait_sig(input int s, input bit v, input int lim, output int n);
    n = 0;
    do begin tick(); n++; end while (sig(s) != v && n < lim);
  endtask
  task automatic pulse_restart();
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, "_pll_rst"}, bus.pll_rst, 1);
    chk({tag, "_sys_rst_n"}, bus.sys_rst_n, 0);
    chk({tag, "_ready"}, bus.ready, 0);
    chk({tag, "_fail"}, bus.fail, 0);
    chk({tag, "_retry"}, bus.retry_cnt, 0);
    chk({tag, "_loss"}, bus.loss_cnt, 0);
  endtask
  initial begin
    int n, hold;
    bus.pll_locked = 1'b0;
    bus.restart = 1'b0;
    #25;
    reset_vals("por");
    @(posedge refclk);
    #1 rst_n = 1'b1;
    wait_sig(S_PLLRST, 0, 100, n);
    chk("rst_pulse_width", n, 4);
    tick(); tick();
    bus.pll_locked = 1'b1;
    wait_sig(S_SYS, 1, 200, n);
    chk("lock_to_release", n, 12);
    chk("clean_ready", bus.ready, 1);
    chk("clean_retry", bus.retry_cnt, 0);
    bus.pll_locked = 1'b0;
    wait_sig(S_SYS, 0, 50, n);
    chk("loss_latency", n, 3);
    chk("loss_pll_rst", bus.pll_rst, 1);
    chk("loss_cnt_once", bus.loss_cnt, LOSS_EN ? 1 : 0);
    wait_sig(S_PLLRST, 0, 50, n);
    chk("loss_repulse", n, 4);
    bus.pll_locked = 1'b1;
    wait_sig(S_SYS, 1, 200, n);
    chk("relock_release", n, 12);
    bus.pll_locked = 1'b0;
    pulse_restart();
    wait_sig(S_PLLRST, 0, 50, n);
    chk("restart_pulse", n, 4);
    bus.pll_locked = 1'b1;
    repeat (6) tick();
    bus.pll_locked = 1'b0;
    repeat (2) tick();
    chk("unstable_no_release", bus.ready, 0);
    bus.pll_locked = 1'b1;
    wait_sig(S_SYS, 1, 200, n);
    chk("unstable_release", n, 12);
    bus.pll_locked = 1'b0;
    pulse_restart();
    wait_sig(S_PLLRST, 0, 50, n);
    chk("tmo_first_pulse", n, 4);
    wait_sig(S_PLLRST, 1, 100, n);
    chk("tmo_gap", n, 32);
    wait_sig(S_PLLRST, 0, 50, n);
    chk("tmo_second_pulse", n, 4);
    chk("tmo_retry1", bus.retry_cnt, 1);
    wait_sig(S_FAIL, 1, 100, n);
    chk("tmo_to_fail", n, 32);
    chk("fail_retry", bus.retry_cnt, 2);
    repeat (20) tick();
    chk("fail_held", bus.fail, 1);
    chk("fail_pll_rst", bus.pll_rst, 0);
    chk("fail_sys_rst_n", bus.sys_rst_n, 0);
    pulse_restart();
    chk("restart_fail_clr", bus.fail, 0);
    chk("restart_retry_clr", bus.retry_cnt, 0);
    chk("restart_pll_rst", bus.pll_rst, 1);
    wait_sig(S_PLLRST, 0, 50, n);
    chk("restart_fail_pulse", n, 4);
    wait_sig(S_PLLRST, 1, 100, n);
    chk("tmo_gap2", n, 32);
    wait_sig(S_PLLRST, 0, 50, n);
    repeat (31) tick();
    pulse_restart();
    chk("restart_vs_tmo_retry", bus.retry_cnt, 0);
    chk("restart_vs_tmo_fail", bus.fail, 0);
    chk("restart_vs_tmo_pll_rst", bus.pll_rst, 1);
    hold = 0;
    repeat (3000) begin
      if (hold == 0) begin
        bus.pll_locked = $urandom_range(0, 3) != 0;
        hold = $urandom_range(1, 40);
      end
      hold--;
      bus.restart = $urandom_range(0, 299) == 0;
      tick();
    end
    bus.restart = 1'b0;
    bus.pll_locked = 1'b1;
    pulse_restart();
    wait_sig(S_READY, 1, 300, n);
    chk("reach_run", bus.ready, 1);
    @(posedge refclk);
    #5 rst_n = 1'b0;
    #2 reset_vals("async");
    #1 rst_n = 1'b1;
    repeat (30) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
